mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- CPU-side initiator for the 64-bit unified data memory and its ready/readdata handshake.
- Accepts one load/store request at a time from the pipeline and drives memread, memwrite, dword, dataadr and writedata.
- Waits out the memory's multi-cycle read latency, then returns a sign- or zero-extended result; the pipeline holds while req_ready is low.

Parameters:
- N, 64, data/address width; must be 64 (big-endian byte lanes within each dword).
- TIMEOUT, 15, maximum clk cycles spent in RD_ISSUE plus RD_WAIT before the read is abandoned.

Ports:
- clk  in  1  single system clock; all state is updated on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller is idle and accepts a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  access size: 1 = W, 2 = B, 3 = D, 0 = invalid (same code as memwrite).
- req_signed  in  1  sign-extend load result.
- req_addr  in  N  byte address.
- req_wdata  in  N  store data, right-aligned.
- resp_valid  out  1  one-cycle pulse: request complete.
- resp_rdata  out  N  formatted load data; 0 for stores.
- resp_err  out  1  qualifies resp_valid: invalid size, timeout, or misalignment.
- memread  out  1  read request to memory.
- memwrite  out  2  write strobe code: 0 = none, 1 = W, 2 = B, 3 = D.
- dword  out  1  64-bit read select.
- dataadr  out  N  latched address.
- writedata  out  N  latched store data.
- ready  in  1  memory idle / read data valid.
- readdata  in  N  memory read data: {32'b0, word} when dword = 0.

Behaviour:
- Reset values: state IDLE; memread 0; memwrite 0; dword 0; dataadr 0; writedata 0; resp_valid 0; resp_rdata 0; resp_err 0; timeout counter 0.
- Reset mid-operation aborts the access and returns to IDLE. No response is issued for the aborted access.
- States: IDLE, RD_ISSUE, RD_WAIT, WR, RESP.
- req_ready = 1 only when state = IDLE and ready = 1. This blocks a new read while the memory is still finishing a read that a reset aborted.
- Accept = req_valid & req_ready. On accept:
  - latch addr, wdata, size, signed and we;
  - dataadr <= req_addr; writedata <= req_wdata; dword <= (size = 3).
- Invalid size at accept: go to RESP with resp_err = 1. No memory strobe is asserted.
- Store path: IDLE -> WR. memwrite = size for exactly one cycle (the memory writes on the rising edge that ends it). WR -> RESP.
- Load path:
  - IDLE -> RD_ISSUE with memread = 1.
  - When ready is seen low: RD_ISSUE -> RD_WAIT and memread drops to 0. memread must not be high in the cycle ready returns to 1, otherwise the memory starts a second read.
  - When ready is seen high: RD_WAIT -> RESP, capturing the formatted readdata.
- Load formatting:
  - D: readdata unchanged.
  - W: readdata[31:0], extended to 64 bits.
  - B: lane = readdata[31-8*addr[1:0] -: 8], extended; byte 0 of a word is its most significant byte. The read is issued with dword = 0.
- RESP lasts one cycle with resp_valid = 1, then returns to IDLE. resp_valid, resp_rdata and resp_err are registered outputs.
- Timeout: the counter runs only in RD_ISSUE/RD_WAIT and clears on entry to RD_ISSUE. When it reaches TIMEOUT: go to RESP, resp_err = 1, resp_rdata = 0, memread = 0.
- Latency with the 5-negedge memory: accept edge k; ready is seen low at k+1; ready is seen high at k+6; resp_valid is high in the cycle after edge k+6. Stores: resp_valid is high in the cycle after edge k+1.
- A req_valid arriving while busy is ignored; the requester holds it until req_ready is high.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined: a W access with addr[1:0] != 0 or a D access with addr[2:0] != 0 goes straight to RESP with resp_err = 1. No strobe is asserted.
- Undefined: low address bits are ignored, as the memory does. No error.

Decomposition:
- Package mem_pkg: size codes SZ_NONE = 0, SZ_W = 1, SZ_B = 2, SZ_D = 3; the state enum; TIMEOUT_DEFAULT.
- One sub-module, load_formatter: purely combinational lane select plus sign/zero extension. It is used in RD_WAIT -> RESP capture.

Test Plan:
- SD to 0x10 with data 0x1122334455667788, then LD from 0x10 -> memwrite = 3 for exactly 1 cycle; load response at k+6 with rdata 0x1122334455667788, err = 0.
- SW 0x80000001 to 0x1C, then LW signed from 0x1C -> 0xFFFFFFFF80000001; unsigned -> 0x0000000080000001.
- SB 0xF0 to 0x09, then LB signed from 0x09 -> 0xFFFFFFFFFFFFFFF0. Also check memwrite = 2, dword = 0, and that memread is 0 when ready rises.
- Hold ready high forever after a load accept -> resp_err = 1 after exactly TIMEOUT = 15 cycles, rdata = 0; controller returns to IDLE.
- Assert reset 2 cycles into a load, then issue req_valid -> req_ready stays 0 until ready = 1. No double read is observed on memread.
- With MEM_ALIGN_CHECK_EN, LD from 0x0C -> resp_err = 1 one cycle after accept, and no memread/memwrite activity.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access controller:
// access size codes, FSM state encoding and the default read timeout.
package mem_pkg;

  localparam logic [1:0] SZ_NONE = 2'd0;
  localparam logic [1:0] SZ_W    = 2'd1;
  localparam logic [1:0] SZ_B    = 2'd2;
  localparam logic [1:0] SZ_D    = 2'd3;

  localparam int TIMEOUT_DEFAULT = 15;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_ISSUE = 3'd1,
    ST_RD_WAIT  = 3'd2,
    ST_WR       = 3'd3,
    ST_RESP     = 3'd4
  } state_e;

endpackage

// File: rtl/load_formatter.sv
// Combinational load-result formatting: big-endian byte lane select within
// the returned word, then sign or zero extension to the full data width.
module load_formatter
  import mem_pkg::*;
#(
  parameter int N = 64
)(
  input  logic [1:0]   size,
  input  logic         sgn,
  input  logic [1:0]   lane,
  input  logic [N-1:0] rdata,
  output logic [N-1:0] fmt
);

  logic [31:0] word;
  logic [7:0]  byte_sel;

  always_comb begin
    word     = rdata[31:0];
    byte_sel = 8'h00;
    // byte 0 of a word is its most significant byte
    case (lane)
      2'd0:    byte_sel = word[31:24];
      2'd1:    byte_sel = word[23:16];
      2'd2:    byte_sel = word[15:8];
      default: byte_sel = word[7:0];
    endcase

    fmt = '0;
    case (size)
      SZ_D:    fmt = rdata;
      SZ_W:    fmt = {{(N-32){sgn & word[31]}}, word};
      SZ_B:    fmt = {{(N-8){sgn & byte_sel[7]}}, byte_sel};
      default: fmt = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// CPU-side load/store initiator for the 64-bit unified data memory.
// Optional build macro MEM_ALIGN_CHECK_EN rejects misaligned W/D accesses.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int N       = 64,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
)(
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [1:0]   req_size,
  input  logic         req_signed,
  input  logic [N-1:0] req_addr,
  input  logic [N-1:0] req_wdata,
  output logic         resp_valid,
  output logic [N-1:0] resp_rdata,
  output logic         resp_err,
  output logic         memread,
  output logic [1:0]   memwrite,
  output logic         dword,
  output logic [N-1:0] dataadr,
  output logic [N-1:0] writedata,
  input  logic         ready,
  input  logic [N-1:0] readdata
);

  localparam int            CW    = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);

  state_e        state;
  logic [CW-1:0] tcnt;
  logic [1:0]    size_q;
  logic          sgn_q;
  logic          accept;
  logic          align_err;
  logic          bad_req;
  logic [N-1:0]  fmt_data;

  // Gating on ready keeps a new read off a memory still finishing an aborted one
  assign req_ready = (state == ST_IDLE) && ready;
  assign accept    = req_valid && req_ready;

`ifdef MEM_ALIGN_CHECK_EN
  assign align_err = ((req_size == SZ_W) && (req_addr[1:0] != 2'b00)) ||
                     ((req_size == SZ_D) && (req_addr[2:0] != 3'b000));
`else
  assign align_err = 1'b0;
`endif

  assign bad_req = (req_size == SZ_NONE) || align_err;

  load_formatter #(.N(N)) u_fmt (
    .size  (size_q),
    .sgn   (sgn_q),
    .lane  (dataadr[1:0]),
    .rdata (readdata),
    .fmt   (fmt_data)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      size_q <= req_size;
      sgn_q  <= req_signed;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      memread    <= 1'b0;
      memwrite   <= SZ_NONE;
      dword      <= 1'b0;
      dataadr    <= '0;
      writedata  <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      tcnt       <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            dataadr   <= req_addr;
            writedata <= req_wdata;
            dword     <= (req_size == SZ_D);
            if (bad_req) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (req_we) begin
              state    <= ST_WR;
              memwrite <= req_size;
            end else begin
              state   <= ST_RD_ISSUE;
              memread <= 1'b1;
              tcnt    <= '0;
            end
          end
        end

        ST_WR: begin
          memwrite   <= SZ_NONE;
          state      <= ST_RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end

        ST_RD_ISSUE, ST_RD_WAIT: begin
          if (tcnt == TLAST) begin
            memread    <= 1'b0;
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
            // memread drops as soon as the memory goes busy, before ready returns
            if (state == ST_RD_ISSUE) begin
              if (!ready) begin
                memread <= 1'b0;
                state   <= ST_RD_WAIT;
              end
            end else if (ready) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_rdata <= fmt_data;
            end
          end
        end

        ST_RESP: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl: byte-array reference model, a 5-negedge
// memory environment and a per-cycle compare process, plus directed literal cases.
`timescale 1ns/1ps
module tb_mem_access_ctrl;
  import mem_pkg::*;

  localparam int N  = 64;
  localparam int TO = 15;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_we = 1'b0;
  logic [1:0]   req_size = 2'd0;
  logic         req_signed = 1'b0;
  logic [N-1:0] req_addr = '0;
  logic [N-1:0] req_wdata = '0;
  logic         resp_valid;
  logic [N-1:0] resp_rdata;
  logic         resp_err;
  logic         memread;
  logic [1:0]   memwrite;
  logic         dword;
  logic [N-1:0] dataadr;
  logic [N-1:0] writedata;
  logic         ready = 1'b1;
  logic [N-1:0] readdata = '0;

  mem_access_ctrl #(.N(N), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .memread(memread), .memwrite(memwrite), .dword(dword),
    .dataadr(dataadr), .writedata(writedata),
    .ready(ready), .readdata(readdata)
  );

  always #5 clk = ~clk;

  int ncheck = 0;
  int nerr   = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    ncheck++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference memory (updated from requests) and environment memory (updated by DUT strobes)
  logic [7:0] ref_mem [256];
  logic [7:0] env_mem [256];

  function automatic logic misalign(input logic [1:0] sz, input logic [63:0] a);
`ifdef MEM_ALIGN_CHECK_EN
    return (sz == SZ_W && a[1:0] != 2'b00) || (sz == SZ_D && a[2:0] != 3'b000);
`else
    return (sz == 2'd3) && (a[63:0] === 64'hx);
`endif
  endfunction

  function automatic logic [63:0] ref_load(input logic [1:0] sz, input logic sg, input logic [63:0] a);
    logic [63:0] r;
    logic [31:0] w;
    logic [7:0]  b;
    int base;
    r = '0;
    w = '0;
    if (sz == SZ_D) begin
      base = int'(a[7:0]) & ~7;
      for (int i = 0; i < 8; i++) r = {r[55:0], ref_mem[base + i]};
    end else if (sz == SZ_W) begin
      base = int'(a[7:0]) & ~3;
      for (int i = 0; i < 4; i++) w = {w[23:0], ref_mem[base + i]};
      r = sg ? {{32{w[31]}}, w} : {32'h0, w};
    end else if (sz == SZ_B) begin
      b = ref_mem[int'(a[7:0])];
      r = sg ? {{56{b[7]}}, b} : {56'h0, b};
    end
    return r;
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [63:0] a, input logic [63:0] wd);
    int base;
    if (sz == SZ_D) begin
      base = int'(a[7:0]) & ~7;
      for (int i = 0; i < 8; i++) ref_mem[base + i] = wd[63 - 8*i -: 8];
    end else if (sz == SZ_W) begin
      base = int'(a[7:0]) & ~3;
      for (int i = 0; i < 4; i++) ref_mem[base + i] = wd[31 - 8*i -: 8];
    end else if (sz == SZ_B) begin
      ref_mem[int'(a[7:0])] = wd[7:0];
    end
  endtask

  // Memory environment: starts a read when it sees memread with ready high,
  // drops ready, and raises it with data on the fifth negedge after that.
  logic       mem_stuck = 1'b0;
  logic       mem_busy  = 1'b0;
  int         mem_cnt   = 0;
  logic [7:0] mem_a     = '0;
  logic       mem_dw    = 1'b0;
  int         reads_started = 0;

  always @(negedge clk) begin
    logic [63:0] r;
    int base;
    if (memwrite == SZ_D) begin
      base = int'(dataadr[7:0]) & ~7;
      for (int i = 0; i < 8; i++) env_mem[base + i] = writedata[63 - 8*i -: 8];
    end else if (memwrite == SZ_W) begin
      base = int'(dataadr[7:0]) & ~3;
      for (int i = 0; i < 4; i++) env_mem[base + i] = writedata[31 - 8*i -: 8];
    end else if (memwrite == SZ_B) begin
      env_mem[int'(dataadr[7:0])] = writedata[7:0];
    end
    if (mem_busy) begin
      if (mem_cnt == 1) begin
        check("memread_at_ready_rise", memread, 1'b0);
        r = '0;
        if (mem_dw) begin
          base = int'(mem_a) & ~7;
          for (int i = 0; i < 8; i++) r = {r[55:0], env_mem[base + i]};
        end else begin
          base = int'(mem_a) & ~3;
          for (int i = 0; i < 4; i++) r = {r[55:0], env_mem[base + i]};
        end
        readdata <= r;
        ready    <= 1'b1;
        mem_busy = 1'b0;
      end else begin
        mem_cnt--;
      end
    end else if (memread === 1'b1 && ready && !mem_stuck) begin
      mem_busy = 1'b1;
      mem_cnt  = 5;
      mem_a    = dataadr[7:0];
      mem_dw   = dword;
      ready    <= 1'b0;
      readdata <= {$urandom, $urandom};
      reads_started++;
    end
  end

  // Behavioural expectations, in absolute cycle numbers
  logic        chk_en = 1'b0;
  logic        exp_pending = 1'b0;
  int          exp_cyc = -1;
  logic        exp_err = 1'b0;
  logic [63:0] exp_data = '0;
  int          mw_cyc = -1;
  logic [1:0]  mw_val = '0;
  int          mr_from = -1, mr_to = -2;
  int          busy_from = -1, busy_to = -2;
  logic        exp_dword = 1'b0;
  logic [63:0] exp_adr = '0;
  int          exp_reads = 0;

  // Observations for the directed literal checks
  int          last_resp_cyc = -100;
  logic        last_err = 1'bx;
  logic [63:0] last_data = 'x;
  int          mw_seen = 0;
  logic [1:0]  mw_last = '0;
  logic        dw_last = 1'b0;
  logic        ev;

  always begin
    @(negedge clk);
    #2;
    if (resp_valid === 1'b1) begin
      last_resp_cyc = cyc;
      last_err      = resp_err;
      last_data     = resp_rdata;
    end
    if (memwrite !== SZ_NONE) begin
      mw_seen++;
      mw_last = memwrite;
      dw_last = dword;
    end
    if (chk_en) begin
      ev = exp_pending && (cyc == exp_cyc);
      check("resp_valid", resp_valid, ev);
      if (ev) begin
        check("resp_err", resp_err, exp_err);
        check("resp_rdata", resp_rdata, exp_data);
        exp_pending = 1'b0;
      end
      check("memwrite", memwrite, (cyc == mw_cyc) ? mw_val : SZ_NONE);
      check("memread", memread, (cyc >= mr_from) && (cyc <= mr_to));
      check("req_ready", req_ready, !((cyc >= busy_from) && (cyc <= busy_to)) && ready);
      if (cyc == mw_cyc || cyc == mr_from) begin
        check("dword", dword, exp_dword);
        check("dataadr", dataadr, exp_adr);
      end
    end
  end

  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [63:0] a, input logic [63:0] wd,
                        input logic wait_done, output int k);
    int n;
    int lat;
    @(negedge clk);
    #1;
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!req_ready) begin
      check("accept_wait", req_ready, 1'b1);
      req_valid = 1'b0;
      k = -1;
      return;
    end
    k = cyc + 1;
    mw_seen = 0;
    if (sz == SZ_NONE || misalign(sz, a)) begin
      lat = 0; exp_err = 1'b1; exp_data = '0;
    end else if (we) begin
      lat = 1; exp_err = 1'b0; exp_data = '0;
      mw_cyc = k; mw_val = sz;
      ref_store(sz, a, wd);
    end else if (mem_stuck) begin
      lat = TO; exp_err = 1'b1; exp_data = '0;
      mr_from = k; mr_to = k + TO - 1;
    end else begin
      lat = 6; exp_err = 1'b0; exp_data = ref_load(sz, sg, a);
      mr_from = k; mr_to = k;
      exp_reads++;
    end
    exp_pending = 1'b1;
    exp_cyc     = k + lat;
    busy_from   = k;
    busy_to     = k + lat;
    exp_dword   = (sz == SZ_D);
    exp_adr     = a;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
    req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
    if (wait_done) begin
      while (cyc <= exp_cyc) begin
        @(negedge clk);
        #3;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d errors of %0d checks so far", nerr, ncheck);
    $fatal(1);
  end

  initial begin
    int k, k2, r0;
    logic [1:0] sz;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 8'($urandom);
      env_mem[i] = ref_mem[i];
    end

    repeat (3) @(negedge clk);
    #1;
    check("rst_state_req_ready", req_ready, 1'b1);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_rdata", resp_rdata, 64'h0);
    check("rst_resp_err", resp_err, 1'b0);
    check("rst_memread", memread, 1'b0);
    check("rst_memwrite", memwrite, 2'd0);
    check("rst_dword", dword, 1'b0);
    check("rst_dataadr", dataadr, 64'h0);
    check("rst_writedata", writedata, 64'h0);
    reset  = 1'b0;
    chk_en = 1'b1;

    // Dword store then load
    do_req(1'b1, SZ_D, 1'b0, 64'h10, 64'h1122334455667788, 1'b1, k);
    check("sd_latency", last_resp_cyc - k, 1);
    check("sd_strobe_cycles", mw_seen, 1);
    check("sd_strobe_code", mw_last, 2'd3);
    check("sd_err", last_err, 1'b0);
    do_req(1'b0, SZ_D, 1'b0, 64'h10, 64'h0, 1'b1, k);
    check("ld_latency", last_resp_cyc - k, 6);
    check("ld_data", last_data, 64'h1122334455667788);
    check("ld_err", last_err, 1'b0);

    // Word store, signed and unsigned reload
    do_req(1'b1, SZ_W, 1'b0, 64'h1C, 64'h80000001, 1'b1, k);
    do_req(1'b0, SZ_W, 1'b1, 64'h1C, 64'h0, 1'b1, k);
    check("lw_signed", last_data, 64'hFFFFFFFF80000001);
    do_req(1'b0, SZ_W, 1'b0, 64'h1C, 64'h0, 1'b1, k);
    check("lw_unsigned", last_data, 64'h0000000080000001);

    // Byte store and signed reload
    do_req(1'b1, SZ_B, 1'b0, 64'h09, 64'hF0, 1'b1, k);
    check("sb_strobe_code", mw_last, 2'd2);
    check("sb_dword", dw_last, 1'b0);
    do_req(1'b0, SZ_B, 1'b1, 64'h09, 64'h0, 1'b1, k);
    check("lb_signed", last_data, 64'hFFFFFFFFFFFFFFF0);

    // Invalid size
    do_req(1'b0, SZ_NONE, 1'b0, 64'h20, 64'h0, 1'b1, k);
    check("inv_latency", last_resp_cyc - k, 0);
    check("inv_err", last_err, 1'b1);

    // Timeout with a memory that never answers
    mem_stuck = 1'b1;
    do_req(1'b0, SZ_D, 1'b0, 64'h20, 64'h0, 1'b1, k);
    mem_stuck = 1'b0;
    check("to_latency", last_resp_cyc - k, TO);
    check("to_err", last_err, 1'b1);
    check("to_data", last_data, 64'h0);
    @(negedge clk);
    #1;
    check("to_idle_after", req_ready, 1'b1);

    // Reset two cycles into a load, then a new load while the memory finishes
    r0 = reads_started;
    do_req(1'b0, SZ_D, 1'b0, 64'h10, 64'h0, 1'b0, k);
    @(negedge clk);
    #1;
    @(negedge clk);
    #1;
    reset = 1'b1;
    busy_to = k + 1;
    exp_pending = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b0;
    check("rst_blocks_req_ready", req_ready, 1'b0);
    check("rst_no_resp", resp_valid, 1'b0);
    do_req(1'b0, SZ_W, 1'b1, 64'h1C, 64'h0, 1'b1, k2);
    check("rst_new_accept_cycle", k2 - k, 6);
    check("rst_new_load_data", last_data, 64'hFFFFFFFF80000001);
    check("rst_read_starts", reads_started - r0, 2);

`ifdef MEM_ALIGN_CHECK_EN
    r0 = reads_started;
    do_req(1'b0, SZ_D, 1'b0, 64'h0C, 64'h0, 1'b1, k);
    check("align_latency", last_resp_cyc - k, 0);
    check("align_err", last_err, 1'b1);
    check("align_no_read", reads_started - r0, 0);
    check("align_no_write", mw_seen, 0);
`endif

    // Randomized traffic over a small address window
    for (int it = 0; it < 150; it++) begin
      sz = ($urandom_range(0, 9) == 0) ? SZ_NONE : 2'($urandom_range(1, 3));
      do_req(1'($urandom), sz, 1'($urandom), 64'($urandom_range(0, 63)),
             {$urandom, $urandom}, 1'b1, k);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    #3;
    check("total_read_starts", reads_started, exp_reads);
    $display("Result: errors=%0d of %0d checks", nerr, ncheck);
    $finish;
  end

endmodule
